fb_sprite_blitter: RTL and testbench
====================================

Name: fb_sprite_blitter

Overview:
- Writer side of the frame buffer that the VGA sprite scanner reads.
- On a start request, copies one SPR_W x SPR_H sprite from a synchronous sprite ROM into the 8-bit RGB332 frame buffer RAM at a screen position.
- Skips transparent-key pixels and clips pixels that fall off-screen.
- Sits between game logic (tank/bullet position updates) and the frame buffer write port.

Parameters:
- FB_WIDTH, 640, frame buffer row length in pixels (visible width).
- FB_HEIGHT, 480, visible rows.
- SPR_W, 32, sprite width in pixels (power of two).
- SPR_H, 32, sprite height in pixels.
- FB_ADDR_W, 19, frame buffer address width.
- ROM_ADDR_W, 10, sprite ROM address width (log2 of SPR_W*SPR_H).
- TRANSPARENT, 8'hE3, RGB332 colour key that is never written.

Ports:
- clk25m  in  1  pixel clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  draw request; sampled only in IDLE.
- dst_x  in  10  sprite top-left x; latched on accepted start.
- dst_y  in  10  sprite top-left y; latched on accepted start.
- busy  out  1  high while a blit is in progress.
- done  out  1  one-cycle pulse when the blit completes.
- rom_addr  out  ROM_ADDR_W  sprite ROM read address, registered.
- rom_data  in  8  sprite ROM data; valid one cycle after rom_addr is sampled by the ROM.
- fb_we  out  1  frame buffer write enable, registered.
- fb_addr  out  FB_ADDR_W  frame buffer write address, registered.
- fb_data  out  8  frame buffer write data (RGB332), registered.

Behaviour:
- Reset: the block enters IDLE. busy, done, fb_we, fb_addr, fb_data and rom_addr are all 0. Reset has immediate effect, including mid-blit: no further writes are issued.
- FSM has three states: IDLE, RUN, FIN.
  - IDLE -> RUN on the edge E0 where start=1. At E0: latch dst_x/dst_y, clear sx/sy, set rom_addr<=0, set busy<=1.
  - RUN: each cycle advance the source address, sx fastest. rom_addr = sy*SPR_W + sx.
  - After the address for pixel N-1 (N=SPR_W*SPR_H) is issued, enter FIN to drain the write pipeline.
  - FIN -> IDLE on the edge where done<=1 and busy<=0. done is high for exactly one cycle.
- Write pipeline:
  - Source coordinates are carried through a 2-stage delay matching ROM latency.
  - The write for pixel i is registered at edge E(i+2).
  - The last write lands at E(N+1); done rises at E(N+2).
  - Throughput is 1 pixel per clock.
- Write condition: fb_we=1 only if all of the following hold:
  - rom_data != TRANSPARENT
  - dst_x+sx < FB_WIDTH, computed in 11 bits with no wrap
  - dst_y+sy < FB_HEIGHT, computed in 11 bits with no wrap
- When fb_we=1:
  - fb_addr = (dst_y+sy)*FB_WIDTH + (dst_x+sx), computed at full width.
  - fb_data = rom_data, unchanged.
- When fb_we=0: fb_addr=0 and fb_data=0.
- start is ignored in RUN and FIN; no queueing.
- A start asserted in the same cycle that done is high is ignored. It must be re-asserted in IDLE.
- dst_x and dst_y changes during a blit have no effect.
- rom_addr returns to 0 in IDLE.
- A sprite fully off-screen still runs all N cycles, performs zero writes, and pulses done.

Test Plan:
- Reset, then idle for 10 cycles -> busy, done and fb_we stay 0; rom_addr, fb_addr and fb_data are 0.
- ROM[i]=i[7:0] (E3 replaced by E2), start at (100,50):
  - 1024 writes on consecutive cycles.
  - First write: fb_addr=32100, data 0x00.
  - Last write: fb_addr=51971, data 0xFF.
  - done is high exactly once, at cycle 1026 after start.
- Even ROM entries = 8'hE3, at (0,0) -> exactly 512 writes, all to odd x; no write carries data E3.
- Start at (620,470) -> exactly 200 writes (20x10); every fb_addr < 307200; done still at cycle 1026.
- Second start pulsed at cycle 5 of a blit -> ignored; exactly one done pulse and 1024 writes.
- rst_n low after 300 writes -> fb_we=0 and busy=0 immediately; a new start after release completes normally from pixel 0.

Source files
------------

// File: rtl/fb_sprite_blitter_if.sv
// Bus bundle between the sprite blitter, its game-logic requester,
// the sprite ROM read port and the frame buffer write port.
interface fb_sprite_blitter_if #(
  parameter int FB_ADDR_W  = 19,
  parameter int ROM_ADDR_W = 10
);
  logic                  start;
  logic [9:0]            dst_x;
  logic [9:0]            dst_y;
  logic                  busy;
  logic                  done;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [7:0]            rom_data;
  logic                  fb_we;
  logic [FB_ADDR_W-1:0]  fb_addr;
  logic [7:0]            fb_data;

  // The blitter drives the ROM address and frame buffer write port
  modport master (
    input  start, dst_x, dst_y, rom_data,
    output busy, done, rom_addr, fb_we, fb_addr, fb_data
  );

  // Game logic, ROM and frame buffer side
  modport slave (
    output start, dst_x, dst_y, rom_data,
    input  busy, done, rom_addr, fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/fb_sprite_blitter.sv
// Sprite blitter: copies one SPR_W x SPR_H sprite from a synchronous ROM
// into the RGB332 frame buffer at (dst_x, dst_y), skipping the colour key
// and clipping anything beyond the visible area. One pixel per clock; the
// sprite coordinates ride a two-stage pipeline that matches ROM latency.
module fb_sprite_blitter #(
  parameter int         FB_WIDTH    = 640,
  parameter int         FB_HEIGHT   = 480,
  parameter int         SPR_W       = 32,
  parameter int         SPR_H       = 32,
  parameter int         FB_ADDR_W   = 19,
  parameter int         ROM_ADDR_W  = 10,
  parameter logic [7:0] TRANSPARENT = 8'hE3
) (
  input logic                 clk25m,
  input logic                 rst_n,
  fb_sprite_blitter_if.master bus
);

  localparam int SX_W = $clog2(SPR_W);
  localparam int SY_W = ROM_ADDR_W - SX_W;
  localparam logic [ROM_ADDR_W-1:0] LAST_ADDR = ROM_ADDR_W'(SPR_W * SPR_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                state;
  logic                  busy_q;
  logic                  done_q;
  logic [ROM_ADDR_W-1:0] rom_addr_q;
  logic [9:0]            org_x;
  logic [9:0]            org_y;

  // Coordinates of the pixel whose ROM data arrives this cycle
  logic                  p1_valid;
  logic [SX_W-1:0]       p1_sx;
  logic [SY_W-1:0]       p1_sy;

  logic                  fb_we_q;
  logic [FB_ADDR_W-1:0]  fb_addr_q;
  logic [7:0]            fb_data_q;

  // Screen position of the arriving pixel, 11 bits wide so it never wraps
  logic [10:0]           pix_x;
  logic [10:0]           pix_y;
  logic                  on_screen;
  logic                  write_ok;
  logic [FB_ADDR_W-1:0]  lin_addr;

  assign pix_x     = {1'b0, org_x} + 11'(p1_sx);
  assign pix_y     = {1'b0, org_y} + 11'(p1_sy);
  assign on_screen = (pix_x < 11'(FB_WIDTH)) && (pix_y < 11'(FB_HEIGHT));
  assign write_ok  = p1_valid && (bus.rom_data != TRANSPARENT) && on_screen;
  assign lin_addr  = FB_ADDR_W'(pix_y) * FB_ADDR_W'(FB_WIDTH) + FB_ADDR_W'(pix_x);

  // Control FSM: accepts a start, walks the ROM address, drains, pulses done
  always_ff @(posedge clk25m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rom_addr_q <= '0;
      org_x      <= '0;
      org_y      <= '0;
      p1_valid   <= 1'b0;
      p1_sx      <= '0;
      p1_sy      <= '0;
    end else begin
      done_q   <= 1'b0;
      p1_valid <= (state == RUN);
      p1_sx    <= rom_addr_q[SX_W-1:0];
      p1_sy    <= rom_addr_q[ROM_ADDR_W-1:SX_W];
      case (state)
        IDLE: begin
          rom_addr_q <= '0;
          // A start coinciding with the done pulse is deliberately dropped
          if (bus.start && !done_q) begin
            org_x  <= bus.dst_x;
            org_y  <= bus.dst_y;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (rom_addr_q == LAST_ADDR) begin
            rom_addr_q <= '0;
            state      <= FIN;
          end else begin
            rom_addr_q <= rom_addr_q + 1'b1;
          end
        end
        FIN: begin
          if (!p1_valid) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write stage: registers one clipped, key-filtered pixel per clock
  always_ff @(posedge clk25m or negedge rst_n) begin
    if (!rst_n) begin
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      fb_we_q   <= write_ok;
      fb_addr_q <= write_ok ? lin_addr : '0;
      fb_data_q <= write_ok ? bus.rom_data : 8'h00;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.fb_we    = fb_we_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_data  = fb_data_q;

endmodule

// File: tb/tb_fb_sprite_blitter.sv
// Randomised bench for fb_sprite_blitter. A behavioural model lists every
// frame buffer write a blit should make (address, colour, cycle after
// start) straight from the sprite/screen geometry; the DUT's write stream
// is compared against that list cycle by cycle.
module tb_fb_sprite_blitter;

  localparam int N        = 1024;
  localparam int DONE_CYC = N + 2;

  logic clk25m = 1'b0;
  logic rst_n;

  always #20 clk25m = ~clk25m;

  fb_sprite_blitter_if #(.FB_ADDR_W(19), .ROM_ADDR_W(10)) bus ();

  fb_sprite_blitter dut (
    .clk25m (clk25m),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  // Synchronous sprite ROM: one cycle read latency
  logic [7:0] rom_mem [N];
  always @(posedge clk25m) bus.rom_data <= rom_mem[bus.rom_addr];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t exp_q [$];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // mode 0: ramp, mode 1: even entries keyed out, mode 2: random colours
  task automatic fill_rom(input int mode);
    logic [7:0] v;
    for (int i = 0; i < N; i++) begin
      v = 8'(i);
      if (mode == 2) v = 8'($urandom);
      if (v == 8'hE3) v = 8'hE2;
      if (mode == 1 && (i % 2) == 0) v = 8'hE3;
      rom_mem[i] = v;
    end
  endtask

  // Every pixel that lands inside 640x480 and is not the key is written,
  // two cycles after its ROM address went out, in raster order
  task automatic build_expected(input int dx, input int dy);
    int   x;
    int   y;
    int   i;
    wr_t  w;
    exp_q.delete();
    for (int sy = 0; sy < 32; sy++) begin
      for (int sx = 0; sx < 32; sx++) begin
        i = sy * 32 + sx;
        x = dx + sx;
        y = dy + sy;
        if (rom_mem[i] != 8'hE3 && x < 640 && y < 480) begin
          w.addr = y * 640 + x;
          w.data = int'(rom_mem[i]);
          w.cyc  = i + 2;
          exp_q.push_back(w);
        end
      end
    end
  endtask

  task automatic applyStimulus(input int dx, input int dy, input int second_start,
                               input int abort_after, input bit start_on_done,
                               input bit check_odd);
    int  n_wr;
    int  n_exp;
    int  done_cnt;
    int  clear_start_at;
    bit  aborted;
    wr_t e;
    n_wr = 0;
    done_cnt = 0;
    clear_start_at = -1;
    aborted = 1'b0;
    build_expected(dx, dy);
    n_exp = exp_q.size();

    @(negedge clk25m);
    bus.start = 1'b1;
    bus.dst_x = 10'(dx);
    bus.dst_y = 10'(dy);
    @(negedge clk25m);
    bus.start = 1'b0;
    bus.dst_x = 10'($urandom);
    bus.dst_y = 10'($urandom);
    checkOutput("busy_e0", 32'(bus.busy), 1);
    checkOutput("rom_addr_e0", 32'(bus.rom_addr), 0);

    for (int c = 1; c <= DONE_CYC + 3; c++) begin
      @(negedge clk25m);
      if (c == clear_start_at) bus.start = 1'b0;
      if (c == second_start) begin
        bus.start = 1'b1;
        bus.dst_x = 10'($urandom);
        bus.dst_y = 10'($urandom);
        clear_start_at = c + 1;
      end
      checkOutput("busy", 32'(bus.busy), 32'(c < DONE_CYC));
      checkOutput("done", 32'(bus.done), 32'(c == DONE_CYC));
      if (bus.done) begin
        done_cnt++;
        if (start_on_done) begin
          bus.start = 1'b1;
          clear_start_at = c + 1;
        end
      end
      if (bus.fb_we) begin
        n_wr++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("wr_addr", 32'(bus.fb_addr), e.addr);
          checkOutput("wr_data", 32'(bus.fb_data), e.data);
          checkOutput("wr_cycle", c, e.cyc);
        end
        if (check_odd) checkOutput("odd_x", (32'(bus.fb_addr) % 640) & 1, 1);
        checkOutput("in_fb", 32'(bus.fb_addr < 19'd307200), 1);
      end else begin
        checkOutput("nowr_addr", 32'(bus.fb_addr), 0);
        checkOutput("nowr_data", 32'(bus.fb_data), 0);
      end
      if (abort_after > 0 && n_wr == abort_after) begin
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_we", 32'(bus.fb_we), 0);
        checkOutput("abort_busy", 32'(bus.busy), 0);
        checkOutput("abort_done", 32'(bus.done), 0);
        checkOutput("abort_rom_addr", 32'(bus.rom_addr), 0);
        aborted = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;

    if (aborted) begin
      repeat (3) begin
        @(negedge clk25m);
        checkOutput("rst_hold_we", 32'(bus.fb_we), 0);
      end
      rst_n = 1'b1;
    end else begin
      checkOutput("wr_count", n_wr, n_exp);
      checkOutput("done_count", done_cnt, 1);
      checkOutput("rom_addr_idle", 32'(bus.rom_addr), 0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.dst_x = '0;
    bus.dst_y = '0;
    fill_rom(0);
    repeat (3) @(negedge clk25m);
    rst_n = 1'b1;

    $display("[TB] idle after reset");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk25m);
      checkOutput("rst_busy", 32'(bus.busy), 0);
      checkOutput("rst_done", 32'(bus.done), 0);
      checkOutput("rst_we", 32'(bus.fb_we), 0);
      checkOutput("rst_rom_addr", 32'(bus.rom_addr), 0);
      checkOutput("rst_fb_addr", 32'(bus.fb_addr), 0);
      checkOutput("rst_fb_data", 32'(bus.fb_data), 0);
    end

    $display("[TB] ramp sprite at (100,50), start held during done");
    fill_rom(0);
    applyStimulus(100, 50, -1, 0, 1'b1, 1'b0);

    $display("[TB] even entries keyed out at (0,0)");
    fill_rom(1);
    applyStimulus(0, 0, -1, 0, 1'b0, 1'b1);

    $display("[TB] clipped corner at (620,470)");
    fill_rom(0);
    applyStimulus(620, 470, -1, 0, 1'b0, 1'b0);

    $display("[TB] second start mid-blit");
    applyStimulus(200, 100, 5, 0, 1'b0, 1'b0);

    $display("[TB] reset after 300 writes, then fresh blit");
    applyStimulus(10, 20, -1, 300, 1'b0, 1'b0);
    applyStimulus(300, 200, -1, 0, 1'b0, 1'b0);

    $display("[TB] fully off-screen sprite");
    fill_rom(2);
    applyStimulus(700, 500, -1, 0, 1'b0, 1'b0);

    $display("[TB] random sprites and positions");
    for (int r = 0; r < 4; r++) begin
      fill_rom(2);
      applyStimulus($urandom_range(0, 700), $urandom_range(0, 520), -1, 0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
